// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// On a hazard or a flush, EX receives an all-zero bubble. Otherwise EX captures the decoded ID instruction.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_read_data_1,
  input  logic [DATA_W-1:0] id_read_data_2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [3:0]        id_alu_op,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [DATA_W-1:0] ex_read_data_1,
  output logic [DATA_W-1:0] ex_read_data_2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic              ex_valid,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [3:0]        alu_op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
  } ex_t;

  ex_t  q;
  ex_t  id_pkt;
  logic haz;

  // Loads that target $0 never produce a value, so they are excluded from the hazard.
  assign haz = q.valid & q.mem_read & (q.dest != 5'd0) &
               ((q.dest == id_rs) | (id_uses_rt & (q.dest == id_rt)));
  assign stall = haz & ~flush;

  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = 1'b1;
    id_pkt.reg_write  = id_reg_write;
    id_pkt.mem_read   = id_mem_read;
    id_pkt.mem_write  = id_mem_write;
    id_pkt.mem_to_reg = id_mem_to_reg;
    id_pkt.alu_src    = id_alu_src;
    id_pkt.alu_op     = id_alu_op;
    id_pkt.rs         = id_rs;
    id_pkt.rt         = id_rt;
    id_pkt.dest       = id_reg_dst ? id_rd : id_rt;
    id_pkt.rd1        = id_read_data_1;
    id_pkt.rd2        = id_read_data_2;
    id_pkt.imm        = id_imm;
    id_pkt.pc4        = id_pc_plus4;
  end

  // A bubble clears every field, so its mem_read is 0 and the same load cannot stall twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q           <= '0;
      stall_count <= '0;
    end else if (!hold) begin
      if (flush) begin
        q <= '0;
      end else if (haz) begin
        q <= '0;
        if (stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
      end else begin
        q <= id_pkt;
      end
    end
  end

  assign ex_valid       = q.valid;
  assign ex_reg_write   = q.reg_write;
  assign ex_mem_read    = q.mem_read;
  assign ex_mem_write   = q.mem_write;
  assign ex_mem_to_reg  = q.mem_to_reg;
  assign ex_alu_src     = q.alu_src;
  assign ex_alu_op      = q.alu_op;
  assign ex_rs          = q.rs;
  assign ex_rt          = q.rt;
  assign ex_dest        = q.dest;
  assign ex_read_data_1 = q.rd1;
  assign ex_read_data_2 = q.rd2;
  assign ex_imm         = q.imm;
  assign ex_pc_plus4    = q.pc4;

endmodule
